aes_key_sched_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_key_sched_ctrl_if.sv | 44 ++++
 rtl/aes_key_round.sv | 32 +++
 rtl/aes_key_sched_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions for the key-schedule slice.
//   - round_key_t     : one 128-bit round key (byte 0 at [7:0], word 0 at [31:0])
//   - AES128_NR/NK    : number of expansion rounds / key length in words
//   - ks_state_e      : key-schedule controller FSM states
//   - sbox(), rcon()  : forward S-box lookup and round-constant lookup
package aes_pkg;

  localparam int AES128_NR = 10;
  localparam int AES128_NK = 4;

  typedef logic [127:0] round_key_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } ks_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at byte position 255-b from the LSB, i.e. at ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: load handshake and round-key read bus of the
// key-schedule controller.
//   key/key_load      : cipher key and load request (master -> slave)
//   busy/keys_ready   : expansion status (slave -> master)
//   rd_idx/rd_key     : registered round-key read port
//   expanded_key      : packed view of all NR+1 round keys
//   zeroize           : store wipe, present only with KEYSCHED_ZEROIZE_EN
interface aes_key_sched_ctrl_if #(
  parameter int NR = 10
);
  import aes_pkg::*;

  round_key_t               key;
  logic                     key_load;
  logic                     busy;
  logic                     keys_ready;
  logic [3:0]               rd_idx;
  round_key_t               rd_key;
  logic [128*(NR+1)-1:0]    expanded_key;
`ifdef KEYSCHED_ZEROIZE_EN
  logic                     zeroize;

  modport master (
    output key, key_load, rd_idx, zeroize,
    input  busy, keys_ready, rd_key, expanded_key
  );

  modport slave (
    input  key, key_load, rd_idx, zeroize,
    output busy, keys_ready, rd_key, expanded_key
  );
`else
  modport master (
    output key, key_load, rd_idx,
    input  busy, keys_ready, rd_key, expanded_key
  );

  modport slave (
    input  key, key_load, rd_idx,
    output busy, keys_ready, rd_key, expanded_key
  );
`endif

endinterface

// File: rtl/aes_key_round.sv
// aes_key_round: one combinational AES-128 key-expansion step.
//   prev_rk : previous round key
//   rcon    : round constant for the round being produced
//   next_rk : next round key
module aes_key_round
  import aes_pkg::*;
(
  input  round_key_t  prev_rk,
  input  logic [7:0]  rcon,
  output round_key_t  next_rk
);

  logic [31:0] rot_s;
  logic [31:0] sub_s;
  round_key_t  nk_s;

  // RotWord/SubWord/rcon on w3, then the chained word XORs.
  always_comb begin
    // byte1 -> byte0 ... byte0 -> byte3
    rot_s = {prev_rk[103:96], prev_rk[127:104]};
    sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]),
             sbox(rot_s[15:8]),  sbox(rot_s[7:0]) ^ rcon};
    nk_s = '0;
    nk_s[31:0] = prev_rk[31:0] ^ sub_s;
    for (int w = 1; w < AES128_NK; w++) begin
      nk_s[32*w +: 32] = prev_rk[32*w +: 32] ^ nk_s[32*(w-1) +: 32];
    end
  end

  assign next_rk = nk_s;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key-schedule controller.
// A load in IDLE captures the cipher key as rk[0]; the following NR cycles
// produce rk[1..NR] through one shared aes_key_round instance.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   kif    : aes_key_sched_ctrl_if.slave (load handshake, status, read port,
//            packed expanded_key view of the store)
// Optional build macro KEYSCHED_ZEROIZE_EN adds kif.zeroize, a synchronous
// wipe of the store/status that outranks key_load.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                       clk,
  input  logic                       reset,
  aes_key_sched_ctrl_if.slave        kif
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  ks_state_e              state_r;
  ks_state_e              state_nx_s;
  logic                   load_acc_s;
  logic                   step_s;
  logic                   zeroize_s;
  logic [3:0]             round_cnt_r;
  round_key_t             rk_r [0:NR];
  round_key_t             prev_rk_s;
  round_key_t             next_rk_s;
  round_key_t             rd_mux_s;
  round_key_t             rd_key_r;
  logic                   busy_r;
  logic                   keys_ready_r;
  logic [128*(NR+1)-1:0]  ek_s;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zeroize_s = kif.zeroize;
`else
  assign zeroize_s = 1'b0;
`endif

  // Source of the shared round datapath: the entry written last cycle.
  always_comb begin
    if (round_cnt_r != 4'd0) begin
      prev_rk_s = rk_r[round_cnt_r - 4'd1];
    end else begin
      prev_rk_s = '0;
    end
  end

  aes_key_round u_key_round (
    .prev_rk (prev_rk_s),
    .rcon    (rcon(round_cnt_r)),
    .next_rk (next_rk_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state plus load-accept / expansion-step strobes.
  always_comb begin
    state_nx_s = state_r;
    load_acc_s = 1'b0;
    step_s     = 1'b0;
    if (zeroize_s) begin
      // Wipe outranks a simultaneous load, which is dropped.
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (kif.key_load) begin
            state_nx_s = ST_EXPAND;
            load_acc_s = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_EXPAND: begin
          // key_load is deliberately not looked at here: no queueing.
          step_s = 1'b1;
          if (round_cnt_r == LAST_RND) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_EXPAND;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Read mux; indices past the last round key read as zero.
  always_comb begin
    if (kif.rd_idx <= LAST_RND) begin
      rd_mux_s = rk_r[kif.rd_idx];
    end else begin
      rd_mux_s = '0;
    end
  end

  // Round-key store, round counter, status flags and registered read port.
  always_ff @(posedge clk) begin
    if (reset || zeroize_s) begin
      for (int i = 0; i <= NR; i++) begin
        rk_r[i] <= '0;
      end
      round_cnt_r  <= 4'd0;
      keys_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      rd_key_r     <= '0;
    end else begin
      busy_r   <= (state_nx_s == ST_EXPAND);
      rd_key_r <= rd_mux_s;
      if (load_acc_s) begin
        rk_r[0]      <= kif.key;
        round_cnt_r  <= 4'd1;
        keys_ready_r <= 1'b0;
      end else if (step_s) begin
        rk_r[round_cnt_r] <= next_rk_s;
        // Counter parks at the last round instead of wrapping.
        if (round_cnt_r == LAST_RND) begin
          keys_ready_r <= 1'b1;
        end else begin
          round_cnt_r <= round_cnt_r + 4'd1;
        end
      end
    end
  end

  // Packed, zero-latency view of the store.
  always_comb begin
    ek_s = '0;
    for (int i = 0; i <= NR; i++) begin
      ek_s[128*i +: 128] = rk_r[i];
    end
  end

  assign kif.expanded_key = ek_s;
  assign kif.busy         = busy_r;
  assign kif.keys_ready   = keys_ready_r;
  assign kif.rd_key       = rd_key_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl (FIPS-197 and all-zero keys,
// read-port table, ignored loads, mid-expansion reset, optional zeroize).
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  localparam int NR = 10;

  logic clk;
  logic reset;

  aes_key_sched_ctrl_if #(.NR(NR)) kif ();

  aes_key_sched_ctrl #(.NR(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  logic [127:0] sb_q [$];

  // Byte list written in reading order -> codebase byte order (byte 0 at [7:0]).
  function automatic logic [127:0] be2le(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [1407:0] act, input logic [1407:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k);
    kif.key      = k;
    kif.key_load = 1'b1;
    tick();
    kif.key_load = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (kif.keys_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_vecs(input string tag, input vec_t tbl [$]);
    logic [127:0] e;
    for (int i = 0; i < tbl.size(); i++) begin
      kif.rd_idx = tbl[i].idx;
      sb_q.push_back(tbl[i].exp);
      tick();
      e = sb_q.pop_front();
      chk($sformatf("%s_rd%0d", tag, tbl[i].idx), kif.rd_key, e);
    end
  endtask

  logic [127:0] fips_key, fips_rk1, fips_rk10, zero_rk1;
  vec_t fips_tbl [$];
  vec_t zero_tbl [$];
  int   n;

  initial begin
    fips_key  = be2le(128'h2b7e151628aed2a6abf7158809cf4f3c);
    fips_rk1  = be2le(128'ha0fafe1788542cb123a339392a6c7605);
    fips_rk10 = be2le(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    zero_rk1  = be2le(128'h62636363626363636263636362636363);

    fips_tbl = '{'{4'd0, fips_key}, '{4'd1, fips_rk1}, '{4'd10, fips_rk10},
                 '{4'd11, 128'h0}, '{4'd15, 128'h0}};
    zero_tbl = '{'{4'd0, 128'h0}, '{4'd1, zero_rk1}, '{4'd11, 128'h0},
                 '{4'd12, 128'h0}, '{4'd13, 128'h0}, '{4'd14, 128'h0},
                 '{4'd15, 128'h0}};

    reset        = 1'b1;
    kif.key      = '0;
    kif.key_load = 1'b0;
    kif.rd_idx   = 4'd0;
`ifdef KEYSCHED_ZEROIZE_EN
    kif.zeroize  = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", kif.busy, 1'b0);
    chk("rst_ready", kif.keys_ready, 1'b0);
    chk("rst_rd_key", kif.rd_key, '0);
    chk("rst_ek", kif.expanded_key, '0);

    // FIPS-197 key: latency and contents.
    do_load(fips_key);
    chk("fips_busy_t1", kif.busy, 1'b1);
    wait_ready(n);
    chk("fips_latency", n, 10);
    chk("fips_busy_done", kif.busy, 1'b0);
    chk("fips_ek_rk1", kif.expanded_key[128 +: 128], fips_rk1);
    chk("fips_ek_rk10", kif.expanded_key[1280 +: 128], fips_rk10);
    run_vecs("fips", fips_tbl);

    // All-zero key through the read port.
    do_load(128'h0);
    chk("zero_ready_clr", kif.keys_ready, 1'b0);
    wait_ready(n);
    chk("zero_latency", n, 10);
    run_vecs("zero", zero_tbl);

    // Loads at T+3 and T+10 are ignored; T+11 is accepted.
    do_load(fips_key);
    repeat (2) tick();
    do_load(128'h0);
    chk("b2b_busy_t3", kif.busy, 1'b1);
    repeat (6) tick();
    do_load(128'h0);
    chk("b2b_ready_t10", kif.keys_ready, 1'b1);
    chk("b2b_busy_t10", kif.busy, 1'b0);
    chk("b2b_rk0", kif.expanded_key[127:0], fips_key);
    chk("b2b_rk1", kif.expanded_key[128 +: 128], fips_rk1);
    chk("b2b_rk10", kif.expanded_key[1280 +: 128], fips_rk10);
    do_load(128'h0);
    chk("b2b_busy_t11", kif.busy, 1'b1);
    chk("b2b_ready_drop", kif.keys_ready, 1'b0);
    wait_ready(n);
    chk("b2b_latency", n, 10);
    chk("b2b_zero_rk1", kif.expanded_key[128 +: 128], zero_rk1);

    // Reset at T+5 of an expansion.
    do_load(fips_key);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", kif.busy, 1'b0);
    chk("mrst_ready", kif.keys_ready, 1'b0);
    chk("mrst_ek", kif.expanded_key, '0);
    do_load(128'h0);
    wait_ready(n);
    chk("mrst_latency", n, 10);
    chk("mrst_rk1", kif.expanded_key[128 +: 128], zero_rk1);

`ifdef KEYSCHED_ZEROIZE_EN
    // Zeroize at T+4 together with a load: store wiped, load dropped.
    do_load(fips_key);
    repeat (3) tick();
    kif.zeroize  = 1'b1;
    kif.key_load = 1'b1;
    kif.key      = fips_key;
    tick();
    kif.zeroize  = 1'b0;
    kif.key_load = 1'b0;
    chk("zer_busy", kif.busy, 1'b0);
    chk("zer_ready", kif.keys_ready, 1'b0);
    chk("zer_ek", kif.expanded_key, '0);
    repeat (2) tick();
    chk("zer_dropped", kif.busy, 1'b0);
    chk("zer_ek_hold", kif.expanded_key, '0);

    // Zeroize with a complete schedule.
    kif.rd_idx = 4'd1;
    do_load(fips_key);
    wait_ready(n);
    chk("zer2_latency", n, 10);
    tick();
    chk("zer2_rd_pre", kif.rd_key, fips_rk1);
    kif.zeroize = 1'b1;
    tick();
    kif.zeroize = 1'b0;
    chk("zer2_ready", kif.keys_ready, 1'b0);
    chk("zer2_rd_key", kif.rd_key, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
